alu_result_stage: RTL and testbench

//  Registered output stage directly downstream of the 16-bit ALU. Captures alu_out,

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_result_stage_if.sv | 58 +++++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/alu_result_stage.sv | 76 +++++++
 tb/tb_alu_result_stage.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU result stage: datapath width,
//                flag bit positions and the packed flags type.
//                No ports (package).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int WIDTH  = 16;

    // Flag bit positions inside flags_t ({N,Z,C,E})
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_E = 0;

    typedef logic [3:0] flags_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_stage_if
//  Description : Bundle of the ALU-side push port, consumer-side pop port and
//                carry feedback signals of the ALU result stage.
//                slave  : the result stage itself
//                master : the environment (ALU producer + writeback consumer)
//                Signals: in_valid/in_ready/in_result/in_carry/in_compare/
//                in_mode, out_valid/out_ready/out_result/out_flags,
//                carry_fb, flags_clr, count.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_stage_if
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic             in_compare;
    logic             in_mode;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    flags_t           out_flags;

    logic             carry_fb;
    logic             flags_clr;
    logic [CW-1:0]    count;

    modport slave (
        input  in_valid, in_result, in_carry, in_compare, in_mode,
        output in_ready,
        output out_valid, out_result, out_flags,
        input  out_ready,
        output carry_fb,
        input  flags_clr,
        output count
    );

    modport master (
        output in_valid, in_result, in_carry, in_compare, in_mode,
        input  in_ready,
        input  out_valid, out_result, out_flags,
        output out_ready,
        input  carry_fb,
        output flags_clr,
        input  count
    );

endinterface : alu_result_stage_if
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO. Head entry is visible on
//                o_rd_data whenever o_rd_valid is high; read data is forced to
//                zero while empty. Storage itself is not reset.
//  Ports       : clk, rst_n (sync, active low)
//                i_wr_en / i_wr_data / o_wr_ready : write side
//                i_rd_en / o_rd_data / o_rd_valid : read side
//                o_count                          : occupied entries
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int DW    = 20,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_wr_en,
    input  wire logic [DW-1:0] i_wr_data,
    output logic               o_wr_ready,
    input  wire logic          i_rd_en,
    output logic [DW-1:0]      o_rd_data,
    output logic               o_rd_valid,
    output logic [CW-1:0]      o_count
);
    localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_not_full;
    logic w_not_empty;
    logic w_push;
    logic w_pop;

    // Both flags come from the registered count only, so there is no
    // combinational path from the read side to the write side.
    assign w_not_full  = (r_count < c_DEPTH_CNT);
    assign w_not_empty = (r_count != '0);
    assign w_push      = i_wr_en & w_not_full;
    assign w_pop       = i_rd_en & w_not_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is plain overflow.
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_wr_ready = w_not_full;
    assign o_rd_valid = w_not_empty;
    assign o_rd_data  = w_not_empty ? r_mem[r_rd_ptr] : '0;
    assign o_count    = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_stage
//  Description : Registered output stage behind the 16-bit ALU. Derives the
//                {N,Z,C,E} flags of each accepted result, buffers result and
//                flags in a show-ahead FIFO towards writeback, and returns a
//                registered carry to the ALU carry_in.
//  Ports       : clk, rst_n (sync, active low)
//                bus : alu_result_stage_if.slave (push/pop handshakes,
//                      carry_fb, flags_clr, count)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    alu_result_stage_if.slave   bus
);
    localparam int DW = WIDTH + 4;

    flags_t           w_flags;
    logic             w_push;
    logic             w_in_ready;
    logic [DW-1:0]    w_rd_data;
    logic             w_rd_valid;
    logic             r_carry_fb;

    // Logic-mode results never report a carry.
    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_N] = bus.in_result[WIDTH-1];
        w_flags[FLAG_Z] = (bus.in_result == '0);
        w_flags[FLAG_C] = bus.in_mode & bus.in_carry;
        w_flags[FLAG_E] = bus.in_compare;
    end

    assign w_push = bus.in_valid & w_in_ready;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (bus.in_valid),
        .i_wr_data  ({w_flags, bus.in_result}),
        .o_wr_ready (w_in_ready),
        .i_rd_en    (bus.out_ready),
        .o_rd_data  (w_rd_data),
        .o_rd_valid (w_rd_valid),
        .o_count    (bus.count)
    );

    // A push takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry_fb <= 1'b0;
        end else if (w_push) begin
            r_carry_fb <= w_flags[FLAG_C];
        end else if (bus.flags_clr) begin
            r_carry_fb <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_rd_valid;
    assign bus.out_result = w_rd_data[WIDTH-1:0];
    assign bus.out_flags  = w_rd_data[DW-1:WIDTH];
    assign bus.carry_fb   = r_carry_fb;

endmodule : alu_result_stage
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_stage
//  Description : Directed self-checking bench for alu_result_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int TW = 16;
    localparam int TD = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_result_stage_if #(.WIDTH(TW), .DEPTH(TD)) bus ();

    alu_result_stage #(.WIDTH(TW), .DEPTH(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are checked
    // at the same point, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_result  = '0;
        bus.in_carry   = 1'b0;
        bus.in_compare = 1'b0;
        bus.in_mode    = 1'b0;
        bus.out_ready  = 1'b0;
        bus.flags_clr  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.count !== 3'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_result !== 16'h0 || bus.out_flags !== 4'h0) begin
            n_fail++; $display("FAIL reset_out: got v=%b r=%h f=%b expected v=0 r=0000 f=0000",
                               bus.out_valid, bus.out_result, bus.out_flags);
        end
        n_checks++;
        if (bus.carry_fb !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cfb_rdy: got cfb=%b rdy=%b expected cfb=0 rdy=1",
                               bus.carry_fb, bus.in_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_logic();
        bus.in_valid = 1'b1; bus.in_result = 16'h0000; bus.in_mode = 1'b0; bus.in_carry = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.in_carry = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0000 || bus.out_flags !== 4'b0100) begin
            n_fail++; $display("FAIL zero_logic: got v=%b r=%h f=%b expected v=1 r=0000 f=0100",
                               bus.out_valid, bus.out_result, bus.out_flags);
        end
        n_checks++;
        if (bus.carry_fb !== 1'b0 || bus.count !== 3'd1) begin
            n_fail++; $display("FAIL zero_logic_cfb: got cfb=%b cnt=%0d expected cfb=0 cnt=1",
                               bus.carry_fb, bus.count);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL zero_logic_pop: got cnt=%0d v=%b expected cnt=0 v=0",
                               bus.count, bus.out_valid);
        end
    endtask

    task automatic test_arith_flags();
        bus.in_valid = 1'b1; bus.in_result = 16'h8001; bus.in_mode = 1'b1;
        bus.in_carry = 1'b1; bus.in_compare = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.out_flags !== 4'b1011 || bus.out_result !== 16'h8001) begin
            n_fail++; $display("FAIL arith_flags: got r=%h f=%b expected r=8001 f=1011",
                               bus.out_result, bus.out_flags);
        end
        n_checks++;
        if (bus.carry_fb !== 1'b1) begin
            n_fail++; $display("FAIL arith_cfb: got %b expected 1", bus.carry_fb);
        end
        // Pop the entry while clearing the carry (no push this cycle)
        bus.flags_clr = 1'b1; bus.out_ready = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.carry_fb !== 1'b0 || bus.count !== 3'd0) begin
            n_fail++; $display("FAIL flags_clr: got cfb=%b cnt=%0d expected cfb=0 cnt=0",
                               bus.carry_fb, bus.count);
        end
    endtask

    task automatic test_full();
        logic exp_rdy;
        for (int i = 1; i <= 5; i++) begin
            bus.in_valid = 1'b1; bus.in_result = 16'(i);
            exp_rdy = (i <= 4);
            #1;
            n_checks++;
            if (bus.in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL full_ready[%0d]: got %b expected %b", i, bus.in_ready, exp_rdy);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_count: got cnt=%0d rdy=%b expected cnt=4 rdy=0",
                               bus.count, bus.in_ready);
        end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 16'(i)) begin
                n_fail++; $display("FAIL drain[%0d]: got v=%b r=%h expected v=1 r=%h",
                                   i, bus.out_valid, bus.out_result, 16'(i));
            end
            bus.out_ready = 1'b1;
            tick();
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_result !== 16'h0) begin
            n_fail++; $display("FAIL drain_empty: got cnt=%0d v=%b r=%h expected cnt=0 v=0 r=0000",
                               bus.count, bus.out_valid, bus.out_result);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_head;
        logic [15:0] next_in;
        exp_head = 16'd100;
        next_in  = 16'd100;
        // Prime two entries
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.in_result = next_in;
            tick();
            next_in++;
        end
        // Stream with simultaneous push and pop across several pointer wraps
        for (int i = 0; i < 3*TD + 2; i++) begin
            bus.in_valid = 1'b1; bus.in_result = next_in; bus.out_ready = 1'b1;
            n_checks++;
            if (bus.out_result !== exp_head) begin
                n_fail++; $display("FAIL stream_head[%0d]: got %h expected %h", i, bus.out_result, exp_head);
            end
            tick();
            next_in++;
            exp_head++;
            n_checks++;
            if (bus.count !== 3'd2) begin
                n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 2", i, bus.count);
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (bus.out_result !== exp_head) begin
                n_fail++; $display("FAIL stream_tail[%0d]: got %h expected %h", i, bus.out_result, exp_head);
            end
            tick();
            exp_head++;
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.count !== 3'd0) begin
            n_fail++; $display("FAIL stream_empty: got %0d expected 0", bus.count);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_result = 16'hA000 + 16'(i);
            bus.in_mode = 1'b1; bus.in_carry = 1'b1;
            tick();
        end
        idle_inputs();
        n_checks++;
        if (bus.count !== 3'd3 || bus.carry_fb !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: got cnt=%0d cfb=%b expected cnt=3 cfb=1",
                               bus.count, bus.carry_fb);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_result !== 16'h0 || bus.carry_fb !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got cnt=%0d v=%b r=%h cfb=%b expected cnt=0 v=0 r=0000 cfb=0",
                               bus.count, bus.out_valid, bus.out_result, bus.carry_fb);
        end
        bus.in_valid = 1'b1; bus.in_result = 16'h1234;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h1234 || bus.count !== 3'd1 ||
            bus.out_flags !== 4'b0000) begin
            n_fail++; $display("FAIL post_reset_push: got v=%b r=%h cnt=%0d f=%b expected v=1 r=1234 cnt=1 f=0000",
                               bus.out_valid, bus.out_result, bus.count, bus.out_flags);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_push_vs_clr();
        bus.in_valid = 1'b1; bus.in_result = 16'h0005; bus.in_mode = 1'b1;
        bus.in_carry = 1'b1; bus.flags_clr = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.carry_fb !== 1'b1) begin
            n_fail++; $display("FAIL push_vs_clr: got cfb=%b expected 1", bus.carry_fb);
        end
        n_checks++;
        if (bus.out_flags !== 4'b0010 || bus.out_result !== 16'h0005) begin
            n_fail++; $display("FAIL push_vs_clr_flags: got r=%h f=%b expected r=0005 f=0010",
                               bus.out_result, bus.out_flags);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.count !== 3'd0 || bus.carry_fb !== 1'b1) begin
            n_fail++; $display("FAIL push_vs_clr_end: got cnt=%0d cfb=%b expected cnt=0 cfb=1",
                               bus.count, bus.carry_fb);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_zero_logic();
        test_arith_flags();
        test_full();
        test_back_to_back();
        test_mid_reset();
        test_push_vs_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_result_stage
`default_nettype wire
